// File: rtl/ones_pattern_enumerator.sv
// ones_pattern_enumerator
//
// Takes a requested ones count k and serially emits every W-bit word whose
// popcount equals k, in ascending numeric order, one word per accepted
// output beat. Used as an exhaustive stimulus source for the ones counter
// datapath and as a reference pattern generator in self-checking benches.
//
// Parameters:
//   W   pattern width (2..8)
//   CW  count width, ceil(log2(W+1))
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   request valid
//   in_count   requested ones count k
//   in_ready   block can accept a request (high while idle)
//   out_valid  out_data holds a word with exactly k ones
//   out_data   current candidate word (zero while idle)
//   out_last   out_data is the final matching word of this request
//   out_ready  consumer accepts the current beat
//   err        one-cycle pulse after a request with k > W was rejected

module ones_pattern_enumerator #(
   parameter int W  = 3,
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [CW-1:0] in_count,
   output logic          in_ready,
   output logic          out_valid,
   output logic [W-1:0]  out_data,
   output logic          out_last,
   input  logic          out_ready,
   output logic          err
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // W held at one extra bit so a count of all ones in CW bits is still
   // compared exactly against the width.
   localparam logic [CW:0] W_LIMIT = (CW+1)'(W);

   state_t        state;
   state_t        state_next;
   logic [W-1:0]  cand;
   logic [W-1:0]  cand_next;
   logic [CW-1:0] k;
   logic [CW-1:0] k_next;
   logic          err_next;
   logic [CW-1:0] pop;
   logic          match;
   logic [W-1:0]  last_pattern;
   logic          over_range;

   // Popcount of the current candidate, accumulated at CW bits so the
   // comparison against k is exact.
   always_comb begin
      pop = '0;
      for (int i = 0; i < W; i++) begin
         pop = pop + CW'(cand[i]);
      end
   end

   // The largest word with k ones has its k ones packed at the top; shifting
   // an all-ones word right by k and inverting gives exactly that, and yields
   // zero for k=0 and all ones for k=W.
   always_comb begin
      match        = (pop == k);
      last_pattern = ~({W{1'b1}} >> k);
      over_range   = ({1'b0, in_count} > W_LIMIT);
   end

   // Outputs are decoded from registered state only, so an asynchronous
   // reset clears them immediately without waiting for a clock edge.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == SCAN) && match;
      out_data  = (state == SCAN) ? cand : '0;
      out_last  = (state == SCAN) && match && (cand == last_pattern);
   end

   // Next-state logic. Non-matching candidates are skipped one per cycle;
   // a matching candidate is held until the consumer takes it, and the
   // final match returns the block to idle instead of incrementing, so the
   // candidate never wraps.
   always_comb begin
      state_next = state;
      cand_next  = cand;
      k_next     = k;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (over_range) begin
                  err_next = 1'b1;
               end else begin
                  k_next     = in_count;
                  cand_next  = '0;
                  state_next = SCAN;
               end
            end
         end
         SCAN: begin
            if (!match) begin
               cand_next = cand + W'(1);
            end else if (out_ready) begin
               if (out_last) begin
                  state_next = IDLE;
               end else begin
                  cand_next = cand + W'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State registers. Reset abandons any request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cand  <= '0;
         k     <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         cand  <= cand_next;
         k     <= k_next;
         err   <= err_next;
      end
   end

endmodule

// File: tb/tb_ones_pattern_enumerator.sv
// tb_ones_pattern_enumerator
//
// Directed bench for ones_pattern_enumerator. A W=3 instance covers the
// scan timing, stalls, reset and exhaustive enumeration; a W=2 instance
// covers rejection of a count larger than the width. Expected values are
// hand-computed or derived from a small ascending-search model.

module tb_ones_pattern_enumerator;

   logic       clk;
   logic       rst;

   logic       in_valid;
   logic [1:0] in_count;
   logic       in_ready;
   logic       out_valid;
   logic [2:0] out_data;
   logic       out_last;
   logic       out_ready;
   logic       err;

   logic       in_valid_b;
   logic [1:0] in_count_b;
   logic       in_ready_b;
   logic       out_valid_b;
   logic [1:0] out_data_b;
   logic       out_last_b;
   logic       out_ready_b;
   logic       err_b;

   int testsRun;
   int failCount;

   ones_pattern_enumerator #(.W(3), .CW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_count  (in_count),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .err       (err)
   );

   ones_pattern_enumerator #(.W(2), .CW(2)) dut_w2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_b),
      .in_count  (in_count_b),
      .in_ready  (in_ready_b),
      .out_valid (out_valid_b),
      .out_data  (out_data_b),
      .out_last  (out_last_b),
      .out_ready (out_ready_b),
      .err       (err_b)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge; on return the bench sits in cycle T+1.
   task automatic applyStimulus(input logic [1:0] count);
      in_valid = 1'b1;
      in_count = count;
      step();
      in_valid = 1'b0;
   endtask

   // Step until the W=3 instance presents a beat, bounded.
   task automatic waitBeat(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      if (!out_valid) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      logic [2:0] exp_valid [8];
      logic [2:0] exp_data  [8];
      logic [2:0] exp_last  [8];
      int         beat_table [4];
      testsRun  = 0;
      failCount = 0;
      in_valid    = 1'b0;
      in_count    = 2'd0;
      out_ready   = 1'b1;
      in_valid_b  = 1'b0;
      in_count_b  = 2'd0;
      out_ready_b = 1'b1;

      // Reset state, observed before any clock edge
      rst = 1'b1;
      #3;
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_err", err, 0);
      #10;
      rst = 1'b0;
      step();
      checkOutput("post_rst_in_ready", in_ready, 1);

      // k=1 with out_ready high: beats 001, 010, 100 at T+2, T+3, T+5
      exp_valid = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
      exp_data  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0};
      exp_last  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
      applyStimulus(2'd1);
      in_count = 2'd3;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("k1_valid_t%0d", i + 1), out_valid, 32'(exp_valid[i]));
         checkOutput($sformatf("k1_data_t%0d", i + 1), out_data, 32'(exp_data[i]));
         checkOutput($sformatf("k1_last_t%0d", i + 1), out_last, 32'(exp_last[i]));
         checkOutput($sformatf("k1_in_ready_t%0d", i + 1), in_ready, 0);
         step();
      end
      checkOutput("k1_in_ready_t6", in_ready, 1);
      checkOutput("k1_valid_t6", out_valid, 0);

      // k=0: single beat 000 with out_last at T+1
      applyStimulus(2'd0);
      checkOutput("k0_valid", out_valid, 1);
      checkOutput("k0_data", out_data, 0);
      checkOutput("k0_last", out_last, 1);
      step();
      checkOutput("k0_in_ready", in_ready, 1);

      // k=3: single beat 111 at T+8; a request during the last beat is ignored
      applyStimulus(2'd3);
      for (int i = 1; i < 8; i++) begin
         checkOutput($sformatf("k3_novalid_t%0d", i), out_valid, 0);
         step();
      end
      checkOutput("k3_valid_t8", out_valid, 1);
      checkOutput("k3_data_t8", out_data, 3'b111);
      checkOutput("k3_last_t8", out_last, 1);
      checkOutput("k3_in_ready_t8", in_ready, 0);
      in_valid = 1'b1;
      in_count = 2'd1;
      step();
      in_valid = 1'b0;
      checkOutput("k3_in_ready_t9", in_ready, 1);
      checkOutput("k3_no_accept_on_last", out_valid, 0);
      step();
      checkOutput("k3_still_idle", in_ready, 1);

      // k=2 with a 3-cycle stall on 011
      out_ready = 1'b0;
      applyStimulus(2'd2);
      checkOutput("k2_t1_valid", out_valid, 0);
      step();
      checkOutput("k2_t2_valid", out_valid, 0);
      step();
      checkOutput("k2_t3_valid", out_valid, 0);
      step();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) out_ready = 1'b1;
         checkOutput($sformatf("k2_hold_valid_%0d", i), out_valid, 1);
         checkOutput($sformatf("k2_hold_data_%0d", i), out_data, 3'b011);
         checkOutput($sformatf("k2_hold_last_%0d", i), out_last, 0);
         step();
      end
      checkOutput("k2_cand4_valid", out_valid, 0);
      step();
      checkOutput("k2_beat2_valid", out_valid, 1);
      checkOutput("k2_beat2_data", out_data, 3'b101);
      checkOutput("k2_beat2_last", out_last, 0);
      step();
      checkOutput("k2_beat3_valid", out_valid, 1);
      checkOutput("k2_beat3_data", out_data, 3'b110);
      checkOutput("k2_beat3_last", out_last, 1);
      step();
      checkOutput("k2_in_ready", in_ready, 1);
      checkOutput("k2_end_valid", out_valid, 0);

      // W=2 instance: count 3 exceeds the width and is rejected
      checkOutput("w2_err_before", err_b, 0);
      in_valid_b = 1'b1;
      in_count_b = 2'd3;
      step();
      in_valid_b = 1'b0;
      checkOutput("w2_err_pulse", err_b, 1);
      checkOutput("w2_in_ready_pulse", in_ready_b, 1);
      checkOutput("w2_valid_pulse", out_valid_b, 0);
      step();
      checkOutput("w2_err_cleared", err_b, 0);
      checkOutput("w2_in_ready_after", in_ready_b, 1);
      checkOutput("w2_valid_after", out_valid_b, 0);

      // Exhaustive W=3 enumeration, checked against a popcount and an
      // ascending-search model of the expected word sequence
      beat_table = '{1, 3, 3, 1};
      out_ready = 1'b1;
      for (int kk = 0; kk < 4; kk++) begin
         int  beats;
         int  next_exp;
         int  n;
         bit  done;
         beats    = 0;
         next_exp = 0;
         n        = 0;
         done     = 1'b0;
         while (next_exp < 8 && $countones(next_exp[2:0]) != kk) next_exp++;
         applyStimulus(2'(kk));
         while (!done && n < 20) begin
            if (out_valid) begin
               beats++;
               checkOutput($sformatf("ex_k%0d_pop", kk), 32'($countones(out_data)), 32'(kk));
               checkOutput($sformatf("ex_k%0d_seq", kk), 32'(out_data), 32'(next_exp));
               done = out_last;
               next_exp++;
               while (next_exp < 8 && $countones(next_exp[2:0]) != kk) next_exp++;
            end
            step();
            n++;
         end
         if (!done) checkOutput($sformatf("ex_k%0d_timeout", kk), 1, 0);
         checkOutput($sformatf("ex_k%0d_beats", kk), 32'(beats), 32'(beat_table[kk]));
         checkOutput($sformatf("ex_k%0d_in_ready", kk), in_ready, 1);
      end

      // Reset during a stalled k=2 beat, then a fresh k=1 request
      out_ready = 1'b0;
      applyStimulus(2'd2);
      waitBeat("rst_stall");
      checkOutput("rst_stall_valid_before", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_stall_valid", out_valid, 0);
      checkOutput("rst_stall_data", out_data, 0);
      checkOutput("rst_stall_last", out_last, 0);
      checkOutput("rst_stall_in_ready", in_ready, 1);
      #2;
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      applyStimulus(2'd1);
      waitBeat("rst_restart");
      checkOutput("rst_restart_first", out_data, 3'b001);
      checkOutput("rst_restart_last", out_last, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
